column_write_arbiter: RTL and testbench



---
 rtl/column_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_column_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/column_write_arbiter.sv
// Two-requester arbiter for the shared 64-column pixel-write bus.
// Round-robin grant, holds the bus until the addressed column acknowledges or the wait times out.
module column_write_arbiter #(
    parameter int N_COLS  = 64,
    parameter int COL_W   = 6,
    parameter int ROW_W   = 10,
    parameter int COLOR_W = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0,
    input  logic [COL_W-1:0]   col0,
    input  logic [ROW_W-1:0]   row0,
    input  logic [COLOR_W-1:0] color0,
    output logic               done0,
    input  logic               req1,
    input  logic [COL_W-1:0]   col1,
    input  logic [ROW_W-1:0]   row1,
    input  logic [COLOR_W-1:0] color1,
    output logic               done1,
    output logic [N_COLS-1:0]  col_select,
    output logic [ROW_W-1:0]   row_select,
    output logic [COLOR_W-1:0] pixel_color,
    input  logic [N_COLS-1:0]  return_sig,
    output logic               busy,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_COLS-1:0]  col_select_q, col_select_d;
    logic [ROW_W-1:0]   row_select_q, row_select_d;
    logic [COLOR_W-1:0] pixel_color_q, pixel_color_d;
    logic [COL_W-1:0]   col_idx_q, col_idx_d;
    logic               grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done0_q, done0_d;
    logic               done1_q, done1_d;
    logic               timeout_err_q, timeout_err_d;

    logic               winner;
    logic [COL_W-1:0]   win_col;
    logic [ROW_W-1:0]   win_row;
    logic [COLOR_W-1:0] win_color;
    logic               ack;

    // On a tie the requester that did not win last time takes the bus.
    assign winner    = (req0 && req1) ? ~last_grant_q : req1;
    assign win_col   = winner ? col1 : col0;
    assign win_row   = winner ? row1 : row0;
    assign win_color = winner ? color1 : color0;
    assign ack       = return_sig[col_idx_q];

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        col_select_d  = col_select_q;
        row_select_d  = row_select_q;
        pixel_color_d = pixel_color_q;
        col_idx_d     = col_idx_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        done0_d       = 1'b0;
        done1_d       = 1'b0;
        timeout_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    col_select_d  = {{(N_COLS-1){1'b0}}, 1'b1} << win_col;
                    row_select_d  = win_row;
                    pixel_color_d = win_color;
                    col_idx_d     = win_col;
                    grant_d       = winner;
                    last_grant_d  = winner;
                    cnt_d         = '0;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack || (cnt_q == CNT_W'(TIMEOUT))) begin
                    col_select_d  = '0;
                    done0_d       = ~grant_q;
                    done1_d       = grant_q;
                    timeout_err_d = ~ack;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            col_select_q  <= '0;
            row_select_q  <= '0;
            pixel_color_q <= '0;
            col_idx_q     <= '0;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_select_q  <= col_select_d;
            row_select_q  <= row_select_d;
            pixel_color_q <= pixel_color_d;
            col_idx_q     <= col_idx_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            done0_q       <= done0_d;
            done1_q       <= done1_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign col_select  = col_select_q;
    assign row_select  = row_select_q;
    assign pixel_color = pixel_color_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_column_write_arbiter.sv
// Randomized bench for column_write_arbiter against a transaction-level model
// of the requesters, round-robin choice, acknowledge latency and timeout.
module tb_column_write_arbiter;

    localparam int N_COLS  = 64;
    localparam int COL_W   = 6;
    localparam int ROW_W   = 10;
    localparam int COLOR_W = 8;
    localparam int TIMEOUT = 1023;
    localparam int NEVER   = 5000;

    logic               clock = 1'b0;
    logic               reset;
    logic               req0, req1;
    logic [COL_W-1:0]   col0, col1;
    logic [ROW_W-1:0]   row0, row1;
    logic [COLOR_W-1:0] color0, color1;
    logic               done0, done1;
    logic [N_COLS-1:0]  col_select;
    logic [ROW_W-1:0]   row_select;
    logic [COLOR_W-1:0] pixel_color;
    logic [N_COLS-1:0]  return_sig;
    logic               busy, timeout_err;

    always #5 clock = ~clock;

    column_write_arbiter #(
        .N_COLS(N_COLS), .COL_W(COL_W), .ROW_W(ROW_W), .COLOR_W(COLOR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .col0(col0), .row0(row0), .color0(color0), .done0(done0),
        .req1(req1), .col1(col1), .row1(row1), .color1(color1), .done1(done1),
        .col_select(col_select), .row_select(row_select), .pixel_color(pixel_color),
        .return_sig(return_sig), .busy(busy), .timeout_err(timeout_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Model: each requester has at most one pending write.
    bit                 pend[2];
    logic [COL_W-1:0]   m_col[2];
    logic [ROW_W-1:0]   m_row[2];
    logic [COLOR_W-1:0] m_color[2];
    int                 last_grant_m;
    logic [ROW_W-1:0]   exp_row;
    logic [COLOR_W-1:0] exp_color;

    task automatic drive_reqs();
        req0 = pend[0]; col0 = m_col[0]; row0 = m_row[0]; color0 = m_color[0];
        req1 = pend[1]; col1 = m_col[1]; row1 = m_row[1]; color1 = m_color[1];
    endtask

    task automatic new_req(input int r, input int col, input int row, input int color);
        pend[r]    = 1'b1;
        m_col[r]   = COL_W'(col);
        m_row[r]   = ROW_W'(row);
        m_color[r] = COLOR_W'(color);
    endtask

    task automatic rand_req(input int r);
        new_req(r, int'($urandom_range(N_COLS-1)), int'($urandom_range(1023)), int'($urandom_range(255)));
    endtask

    // One full write starting from IDLE; the addressed column acks after `delay` WAIT cycles.
    task automatic run_txn(input int delay, input bit noise_all);
        int          w;
        int          done_at;
        bit          to;
        logic [63:0] onehot;
        logic [63:0] ret;
        drive_reqs();
        if (pend[0] && pend[1]) w = 1 - last_grant_m;
        else                    w = pend[1] ? 1 : 0;
        last_grant_m = w;
        step();
        onehot = 64'd1 << m_col[w];
        check("grant_col_select", 64'(col_select), onehot);
        check("grant_row_select", 64'(row_select), 64'(m_row[w]));
        check("grant_pixel_color", 64'(pixel_color), 64'(m_color[w]));
        check("grant_busy", 64'(busy), 64'd1);
        check("grant_done", 64'({done1, done0}), 64'd0);
        exp_row   = m_row[w];
        exp_color = m_color[w];
        // Winner's data inputs are no longer looked at once granted.
        if (w == 0) begin
            col0 = COL_W'($urandom); row0 = ROW_W'($urandom); color0 = COLOR_W'($urandom);
        end else begin
            col1 = COL_W'($urandom); row1 = ROW_W'($urandom); color1 = COLOR_W'($urandom);
        end
        to      = (delay > TIMEOUT);
        done_at = to ? TIMEOUT : delay;
        for (int k = 0; k <= done_at; k++) begin
            ret = noise_all ? ~64'd0 : {$urandom, $urandom};
            ret[m_col[w]] = (k >= delay);
            return_sig = ret;
            step();
            if (k < done_at) begin
                check("wait_col_select", 64'(col_select), onehot);
                check("wait_done", 64'({done1, done0, timeout_err}), 64'd0);
            end
        end
        check("done_winner", 64'({done1, done0}), (w == 1) ? 64'd2 : 64'd1);
        check("done_timeout_err", 64'(timeout_err), 64'(to));
        check("done_col_select", 64'(col_select), 64'd0);
        check("done_busy", 64'(busy), 64'd1);
        pend[w] = 1'b0;
        drive_reqs();
        return_sig = {$urandom, $urandom};
        step();
        check("idle_done", 64'({done1, done0, timeout_err}), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_col_select", 64'(col_select), 64'd0);
        check("idle_row_kept", 64'(row_select), 64'(exp_row));
        check("idle_color_kept", 64'(pixel_color), 64'(exp_color));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            m_col[r] = '0; m_row[r] = '0; m_color[r] = '0;
        end
        drive_reqs();
        return_sig = '0;
        last_grant_m = 1;
        step(); step(); step();
        check("reset_col_select", 64'(col_select), 64'd0);
        check("reset_row_select", 64'(row_select), 64'd0);
        check("reset_pixel_color", 64'(pixel_color), 64'd0);
        check("reset_done", 64'({done1, done0, timeout_err}), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        step();
        check("post_reset_busy", 64'(busy), 64'd0);

        // Basic write: column 5, ack two cycles after the strobe.
        new_req(0, 5, 37, 255);
        run_txn(2, 1'b0);

        // Continuous contention between column 3 and column 60.
        new_req(0, 3, int'($urandom_range(1023)), int'($urandom_range(255)));
        new_req(1, 60, int'($urandom_range(1023)), int'($urandom_range(255)));
        for (int i = 0; i < 6; i++) begin
            run_txn(int'($urandom_range(3)), 1'b0);
            if (i < 5) begin
                if (!pend[0]) new_req(0, 3, int'($urandom_range(1023)), int'($urandom_range(255)));
                if (!pend[1]) new_req(1, 60, int'($urandom_range(1023)), int'($urandom_range(255)));
            end
        end
        while (pend[0] || pend[1]) run_txn(1, 1'b0);

        // Missing acknowledge on column 10 while every other column acks.
        new_req(0, 10, int'($urandom_range(1023)), int'($urandom_range(255)));
        run_txn(NEVER, 1'b1);
        rand_req(1);
        run_txn(1, 1'b0);

        // Reset in the middle of a requester-0 write.
        rand_req(0);
        drive_reqs();
        return_sig = '0;
        step();
        check("pre_reset_grant", 64'(col_select), 64'd1 << m_col[0]);
        step();
        reset = 1'b1;
        step();
        check("midreset_col_select", 64'(col_select), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'({done1, done0, timeout_err}), 64'd0);
        reset = 1'b0;
        pend[0] = 1'b0;
        drive_reqs();
        last_grant_m = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_reset_quiet", 64'({done1, done0, busy}), 64'd0);
        end
        rand_req(0);
        rand_req(1);
        run_txn(0, 1'b0);
        while (pend[0] || pend[1]) run_txn(0, 1'b0);

        // Requester 1 alone with the ack already present at the grant.
        rand_req(1);
        run_txn(0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 60; t++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && ($urandom_range(1) == 1)) rand_req(r);
            if (!pend[0] && !pend[1]) rand_req(int'($urandom_range(1)));
            run_txn(int'($urandom_range(6)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
